// File: rtl/gpio_serial_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// gpio_serial_arbiter_pkg : shared state encoding and constants
// Revision 1.0
// ============================================================================
package gpio_serial_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        SHIFT = 3'd3,
        LOAD  = 3'd4,
        DONE  = 3'd5
    } arb_state_t;

    localparam int REQ_MGMT    = 0;
    localparam int REQ_HK      = 1;
    localparam int LOAD_PHASES = 4;

    // Counter width that stays legal when the count is 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_serial_rr2.sv
`default_nettype none
// ============================================================================
// gpio_serial_rr2 : 2-way round-robin arbiter with registered one-hot grant
// Revision 1.0
// ============================================================================
module gpio_serial_rr2
    import gpio_serial_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    input  logic       clr,
    output logic [1:0] gnt
);

    logic       r_last;
    logic [1:0] r_gnt;
    logic       w_pick;

    // Housekeeping wins when it asks alone or when management won last time.
    assign w_pick = req[REQ_HK] & (~req[REQ_MGMT] | (r_last == 1'(REQ_MGMT)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'(REQ_HK);
            r_gnt  <= 2'b00;
        end else if (clr) begin
            r_gnt  <= 2'b00;
        end else if (en && (req != 2'b00)) begin
            r_gnt  <= w_pick ? 2'b10 : 2'b01;
            r_last <= w_pick;
        end
    end

    assign gnt = r_gnt;

endmodule
`default_nettype wire

// File: rtl/gpio_serial_arbiter.sv
`default_nettype none
// ============================================================================
// gpio_serial_arbiter : shares the GPIO serial config chain between two masters
// Revision 1.0
// ============================================================================
module gpio_serial_arbiter
    import gpio_serial_arbiter_pkg::*;
#(
    parameter int IO_PADS      = 32,
    parameter int IO_CTRL_BITS = 13,
    parameter int CLK_DIV      = 1,
    parameter int PAD_IDX_W    = 6
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic [1:0]              req_i,
    output logic [1:0]              gnt_o,
    output logic [1:0]              done_o,
    output logic                    busy_o,
    output logic                    cfg_rd_en_o,
    output logic                    cfg_rd_sel_o,
    output logic [PAD_IDX_W-1:0]    cfg_rd_idx_o,
    input  logic [IO_CTRL_BITS-1:0] cfg_rd_data_i,
    output logic                    serial_clock,
    output logic                    serial_resetn,
    output logic                    serial_data_out
);

    localparam int BIT_W = cnt_width(IO_CTRL_BITS);
    localparam int DIV_W = cnt_width(CLK_DIV);

    localparam logic [BIT_W-1:0]     C_LAST_BIT   = BIT_W'(IO_CTRL_BITS - 1);
    localparam logic [DIV_W-1:0]     C_LAST_DIV   = DIV_W'(CLK_DIV - 1);
    localparam logic [PAD_IDX_W-1:0] C_FIRST_PAD  = PAD_IDX_W'(IO_PADS - 1);
    localparam logic [1:0]           C_LAST_LPH   = 2'(LOAD_PHASES - 1);
    localparam logic [1:0]           C_LPH_TRAIL  = 2'd1;
    localparam logic [1:0]           C_LPH_STROBE = 2'd2;

    arb_state_t              r_state, w_state_nxt;
    logic [PAD_IDX_W-1:0]    r_pad, w_pad_nxt;
    logic [BIT_W-1:0]        r_bit, w_bit_nxt;
    logic [DIV_W-1:0]        r_div, w_div_nxt;
    logic                    r_phase, w_phase_nxt;
    logic [1:0]              r_lph, w_lph_nxt;
    logic [IO_CTRL_BITS-1:0] r_stage, w_stage_nxt;
    logic                    r_sclk, w_sclk_nxt;
    logic                    r_srstn, w_srstn_nxt;

    logic       w_div_end;
    logic       w_arb_en;
    logic       w_arb_clr;
    logic [1:0] w_gnt;

    gpio_serial_rr2 u_rr2 (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .req (req_i),
        .en  (w_arb_en),
        .clr (w_arb_clr),
        .gnt (w_gnt)
    );

    assign w_div_end = (r_div == C_LAST_DIV);

    always_comb begin
        w_state_nxt = r_state;
        w_pad_nxt   = r_pad;
        w_bit_nxt   = r_bit;
        w_div_nxt   = r_div;
        w_phase_nxt = r_phase;
        w_lph_nxt   = r_lph;
        w_stage_nxt = r_stage;
        w_arb_en    = 1'b0;
        w_arb_clr   = 1'b0;
        w_sclk_nxt  = 1'b0;
        w_srstn_nxt = 1'b1;

        case (r_state)
            IDLE: begin
                w_arb_en = 1'b1;
                if (req_i != 2'b00) begin
                    w_state_nxt = FETCH;
                    w_pad_nxt   = C_FIRST_PAD;
                end
            end
            FETCH: begin
                w_state_nxt = WAIT;
            end
            WAIT: begin
                w_stage_nxt = cfg_rd_data_i;
                w_bit_nxt   = '0;
                w_div_nxt   = '0;
                w_phase_nxt = 1'b0;
                w_state_nxt = SHIFT;
            end
            SHIFT: begin
                w_div_nxt = r_div + DIV_W'(1);
                if (w_div_end) begin
                    w_div_nxt   = '0;
                    w_phase_nxt = ~r_phase;
                    // Data moves only on the high-to-low transition of the chain clock.
                    if (r_phase) begin
                        w_stage_nxt = r_stage << 1;
                        w_bit_nxt   = r_bit + BIT_W'(1);
                        if (r_bit == C_LAST_BIT) begin
                            if (r_pad == '0) begin
                                w_state_nxt = LOAD;
                                w_lph_nxt   = '0;
                            end else begin
                                w_state_nxt = FETCH;
                                w_pad_nxt   = r_pad - PAD_IDX_W'(1);
                            end
                        end
                    end
                end
            end
            LOAD: begin
                w_div_nxt = r_div + DIV_W'(1);
                if (w_div_end) begin
                    w_div_nxt = '0;
                    w_lph_nxt = r_lph + 2'd1;
                    if (r_lph == C_LAST_LPH) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                w_arb_clr   = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Chain pins are registered from the next-state view so they never glitch.
        if (w_state_nxt == SHIFT) begin
            w_sclk_nxt = w_phase_nxt;
        end
        if (w_state_nxt == LOAD) begin
            w_sclk_nxt  = (w_lph_nxt == C_LPH_TRAIL) || (w_lph_nxt == C_LPH_STROBE);
            w_srstn_nxt = (w_lph_nxt != C_LPH_STROBE);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
            r_pad   <= '0;
            r_bit   <= '0;
            r_div   <= '0;
            r_phase <= 1'b0;
            r_lph   <= '0;
            r_stage <= '0;
            r_sclk  <= 1'b0;
            r_srstn <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pad   <= w_pad_nxt;
            r_bit   <= w_bit_nxt;
            r_div   <= w_div_nxt;
            r_phase <= w_phase_nxt;
            r_lph   <= w_lph_nxt;
            r_stage <= w_stage_nxt;
            r_sclk  <= w_sclk_nxt;
            r_srstn <= w_srstn_nxt;
        end
    end

    assign gnt_o           = w_gnt;
    assign done_o          = (r_state == DONE) ? w_gnt : 2'b00;
    assign busy_o          = (r_state != IDLE);
    assign cfg_rd_en_o     = (r_state == FETCH);
    assign cfg_rd_sel_o    = w_gnt[REQ_HK];
    assign cfg_rd_idx_o    = r_pad;
    assign serial_clock    = r_sclk;
    assign serial_resetn   = r_srstn;
    assign serial_data_out = r_stage[IO_CTRL_BITS-1];

endmodule
`default_nettype wire

// File: tb/tb_gpio_serial_arbiter.sv
`default_nettype none
// ============================================================================
// tb_gpio_serial_arbiter : scoreboard bench, two chain geometries side by side
// Revision 1.0
// ============================================================================
module tb_gpio_serial_arbiter;

    localparam int BITS = 13;
    localparam int PW   = 6;

    typedef struct {
        int          who;
        logic [63:0] stream;
        int          nbits;
        int          cycles;
        int          pads;
        int          div;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [1:0]    req    [2];
    logic [1:0]    gnt    [2];
    logic [1:0]    done   [2];
    logic          busy   [2];
    logic          rd_en  [2];
    logic          rd_sel [2];
    logic [PW-1:0] rd_idx [2];
    logic          sclk   [2];
    logic          srstn  [2];
    logic          sdo    [2];

    logic [BITS-1:0] mem [2][2][2];
    int   last [2];
    exp_t q0[$];
    exp_t q1[$];

    function automatic int pads_of(input int g);
        return (g == 0) ? 2 : 1;
    endfunction

    function automatic int div_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, expv, $time);
        end
    endtask

    // Reference: stream is every pad word, highest pad first, MSB first.
    task automatic push_exp(input int g, input int w);
        exp_t e;
        e.who    = w;
        e.pads   = pads_of(g);
        e.div    = div_of(g);
        e.stream = '0;
        for (int p = e.pads - 1; p >= 0; p--)
            e.stream = (e.stream << BITS) | 64'(mem[g][w][p]);
        e.nbits  = e.pads * BITS;
        e.cycles = e.pads * (2 + 2 * e.div * BITS) + 4 * e.div;
        if (g == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic arb_push(input int g, input logic [1:0] r);
        int w;
        if (r == 2'b11) w = 1 - last[g];
        else            w = r[1] ? 1 : 0;
        last[g] = w;
        push_exp(g, w);
    endtask

    task automatic issue(input int g, input logic [1:0] r);
        int n;
        n = 0;
        @(negedge clk);
        while (busy[g] !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 64'(n >= 3000), 0);
        arb_push(g, r);
        req[g] = r;
    endtask

    task automatic wait_done(input int g);
        int n;
        n = 0;
        @(negedge clk);
        while (done[g] === 2'b00 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", 64'(n >= 3000), 0);
    endtask

    task automatic chk_reset(input int g);
        chk("rst_gnt",   gnt[g],   0);
        chk("rst_done",  done[g],  0);
        chk("rst_busy",  busy[g],  0);
        chk("rst_rd_en", rd_en[g], 0);
        chk("rst_sclk",  sclk[g],  0);
        chk("rst_srstn", srstn[g], 0);
        chk("rst_sdo",   sdo[g],   0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk_reset(0);
        chk_reset(1);
        #1 rst = 1'b0;
        last[0] = 1;
        last[1] = 1;
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_cfg
        localparam int P = (g == 0) ? 2 : 1;
        localparam int D = (g == 0) ? 1 : 3;

        logic [BITS-1:0] rd_data;
        logic            pend = 1'b0;
        logic [BITS-1:0] word = '0;

        gpio_serial_arbiter #(
            .IO_PADS      (P),
            .IO_CTRL_BITS (BITS),
            .CLK_DIV      (D),
            .PAD_IDX_W    (PW)
        ) dut (
            .wb_clk_i        (clk),
            .wb_rst_i        (rst),
            .req_i           (req[g]),
            .gnt_o           (gnt[g]),
            .done_o          (done[g]),
            .busy_o          (busy[g]),
            .cfg_rd_en_o     (rd_en[g]),
            .cfg_rd_sel_o    (rd_sel[g]),
            .cfg_rd_idx_o    (rd_idx[g]),
            .cfg_rd_data_i   (rd_data),
            .serial_clock    (sclk[g]),
            .serial_resetn   (srstn[g]),
            .serial_data_out (sdo[g])
        );

        // Register file: word valid only in the cycle after the strobe, noise otherwise.
        always @(negedge clk) begin
            rd_data = pend ? word : BITS'($urandom);
            pend    = rd_en[g];
            word    = mem[g][rd_sel[g]][rd_idx[g][0]];
        end

        bit          act = 1'b0;
        bit          idle_chk = 1'b0;
        bit          rogue = 1'b0;
        bit          gnt_bad;
        int          cyc, nrise, nbits, nfetch, nlow, nlow_bad, qs;
        logic [63:0] got;
        logic        sclk_q;
        exp_t        e;

        always @(negedge clk) begin
            qs = (g == 0) ? q0.size() : q1.size();
            if (rst) begin
                act      = 1'b0;
                idle_chk = 1'b0;
                rogue    = 1'b0;
            end else if (idle_chk) begin
                idle_chk = 1'b0;
                chk("gnt_cleared", gnt[g], 0);
                chk("idle_after_done", busy[g], 0);
            end else if (rogue) begin
                if (gnt[g] === 2'b00) rogue = 1'b0;
            end else if (!act) begin
                if (done[g] !== 2'b00) chk("stray_done", done[g], 0);
                if (gnt[g] !== 2'b00) begin
                    if (qs == 0) begin
                        chk("unexpected_grant", gnt[g], 0);
                        rogue = 1'b1;
                    end else begin
                        if (g == 0) e = q0.pop_front();
                        else        e = q1.pop_front();
                        chk("grant", gnt[g], (e.who == 1) ? 2'b10 : 2'b01);
                        act = 1'b1; cyc = 0; nrise = 0; nbits = 0; nfetch = 0;
                        nlow = 0; nlow_bad = 0; got = '0; sclk_q = 1'b0; gnt_bad = 1'b0;
                    end
                end
            end

            if (act) begin
                if (gnt[g] !== ((e.who == 1) ? 2'b10 : 2'b01)) gnt_bad = 1'b1;
                if (rd_en[g] === 1'b1) begin
                    chk("rd_idx", 64'(rd_idx[g]), 64'(e.pads - 1 - nfetch));
                    chk("rd_sel", rd_sel[g], 64'(e.who));
                    nfetch++;
                end
                if (sclk[g] === 1'b1 && sclk_q === 1'b0) begin
                    nrise++;
                    if (nbits < e.nbits) begin
                        got = {got[62:0], sdo[g]};
                        nbits++;
                    end
                end
                sclk_q = sclk[g];
                if (srstn[g] === 1'b0) begin
                    nlow++;
                    if (sclk[g] !== 1'b1) nlow_bad++;
                end
                if (done[g] !== 2'b00) begin
                    chk("done_onehot", done[g], (e.who == 1) ? 2'b10 : 2'b01);
                    chk("latency", 64'(cyc), 64'(e.cycles));
                    chk("rising_edges", 64'(nrise), 64'(e.nbits + 1));
                    chk("stream", got, e.stream);
                    chk("fetch_count", 64'(nfetch), 64'(e.pads));
                    chk("load_low_cycles", 64'(nlow), 64'(e.div));
                    chk("load_low_clk_high", 64'(nlow_bad), 0);
                    chk("gnt_held", 64'(gnt_bad), 0);
                    act      = 1'b0;
                    idle_chk = 1'b1;
                end else begin
                    cyc++;
                    if (cyc > e.cycles + 20) begin
                        chk("transfer_timeout", 64'(cyc), 64'(e.cycles));
                        act = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        req[0] = 2'b00;
        req[1] = 2'b00;
        last[0] = 1;
        last[1] = 1;
        for (int g = 0; g < 2; g++)
            for (int w = 0; w < 2; w++)
                for (int p = 0; p < 2; p++)
                    mem[g][w][p] = BITS'($urandom);
        mem[0][0][1] = 13'h1801;
        mem[0][0][0] = 13'h0403;

        do_reset();

        // Single management request on the 2-pad chain.
        issue(0, 2'b01);
        wait_done(0);
        req[0] = 2'b00;

        // Both held from reset: 0, 1, 0.
        do_reset();
        issue(0, 2'b11);
        arb_push(0, 2'b11);
        arb_push(0, 2'b11);
        wait_done(0);
        wait_done(0);
        wait_done(0);
        req[0] = 2'b00;

        // Slow chain, single pad.
        issue(1, 2'b01);
        wait_done(1);
        req[1] = 2'b00;
        issue(1, 2'b10);
        wait_done(1);
        req[1] = 2'b00;
        issue(1, 2'b11);
        wait_done(1);
        req[1] = 2'b00;

        // Reset during pad 0, bit 5, then a fresh transfer.
        issue(0, 2'b01);
        repeat (40) @(negedge clk);
        do_reset();
        arb_push(0, 2'b01);
        wait_done(0);
        req[0] = 2'b00;

        // Housekeeping pulse mid-transfer is lost.
        issue(0, 2'b01);
        repeat (10) @(negedge clk);
        req[0] = 2'b11;
        @(negedge clk);
        req[0] = 2'b01;
        wait_done(0);
        req[0] = 2'b00;
        repeat (30) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            int         g;
            logic [1:0] r;
            g = i % 2;
            for (int w = 0; w < 2; w++)
                for (int p = 0; p < 2; p++)
                    mem[g][w][p] = BITS'($urandom);
            r = 2'($urandom_range(1, 3));
            issue(g, r);
            wait_done(g);
            req[g] = 2'b00;
        end

        repeat (20) @(negedge clk);
        chk("q0_drained", 64'(q0.size()), 0);
        chk("q1_drained", 64'(q1.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
